// File: rtl/mips_multicycle_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control unit for a multicycle MIPS datapath. It owns the instruction-phase
// state register, the memory-wait handshake, a stall timeout and a sticky
// fault flag. It turns the registered phase, the IR contents and the memory
// wait request into every datapath strobe.
//
// Supported: ADDU SUBU AND OR SLT (R-type), ADDIU LW SW BEQ BNE J JR.
// Any other encoding is fetched and then dropped (behaves as a NOP).
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   instr        IR contents (opcode [31:26], func [5:0])
//   reg_a        rs read value, used to detect the JR-to-zero halt
//   mem_waitreq  memory is stalling the current access
//   RegDst       register destination select (1 = rd, 0 = rt)
//   RegWrite     register file write enable
//   ALUSrcA      ALU operand A (0 = PC, 1 = reg A)
//   ALUSrcB      ALU operand B (00 B, 01 4, 10 sext imm, 11 sext imm<<2)
//   ALUctl       ALU op (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111)
//   PCSource     PC source (00 ALU, 01 ALUOut, 10 jump target, 11 reg A)
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load when (zero XOR BranchNe)
//   BranchNe     high for BNE
//   IorD         memory address select (0 = PC, 1 = ALUOut)
//   MemRead      memory read strobe
//   MemWrite     memory write strobe
//   MemtoReg     write-back data select (1 = MDR, 0 = ALUOut)
//   IRWrite      IR load
//   active       high unless in IDLE, HALT or FAULT
//   fault        sticky memory-wait timeout flag
//   state        current phase (IDLE 0 .. FAULT 7)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int DATA_W     = 32,
  parameter int TIMEOUT_W  = 8,
  parameter int WAIT_LIMIT = 200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] reg_a,
  input  logic              mem_waitreq,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [3:0]        ALUctl,
  output logic [1:0]        PCSource,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic              BranchNe,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              IRWrite,
  output logic              active,
  output logic              fault,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};
  localparam logic [31:0]          LIMIT   = 32'(WAIT_LIMIT);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 fault_q, fault_d;

  logic [5:0]           opcode;
  logic [5:0]           func;
  logic                 is_rtype_alu;
  logic                 is_jr;
  logic                 is_j;
  logic                 is_addiu;
  logic                 is_lw;
  logic                 is_sw;
  logic                 is_beq;
  logic                 is_bne;
  logic                 is_known;
  logic [3:0]           rtype_alu_ctl;
  logic [TIMEOUT_W-1:0] wait_inc;
  logic                 wait_limit_hit;
  logic                 unused_instr_bits;

  // Only the opcode and func fields steer control; register and immediate
  // fields are consumed by the datapath.
  assign unused_instr_bits = ^instr[25:6];

  // Instruction class decode from the IR.
  always_comb begin
    opcode       = instr[31:26];
    func         = instr[5:0];
    is_rtype_alu = (opcode == OP_RTYPE) &&
                   ((func == FN_ADDU) || (func == FN_SUBU) || (func == FN_AND) ||
                    (func == FN_OR)   || (func == FN_SLT));
    is_jr        = (opcode == OP_RTYPE) && (func == FN_JR);
    is_j         = (opcode == OP_J);
    is_addiu     = (opcode == OP_ADDIU);
    is_lw        = (opcode == OP_LW);
    is_sw        = (opcode == OP_SW);
    is_beq       = (opcode == OP_BEQ);
    is_bne       = (opcode == OP_BNE);
    is_known     = is_rtype_alu | is_jr | is_j | is_addiu | is_lw | is_sw |
                   is_beq | is_bne;
  end

  // ALU operation for R-type arithmetic, selected by func.
  always_comb begin
    rtype_alu_ctl = ALU_ADD;
    case (func)
      FN_ADDU: rtype_alu_ctl = ALU_ADD;
      FN_SUBU: rtype_alu_ctl = ALU_SUB;
      FN_AND:  rtype_alu_ctl = ALU_AND;
      FN_OR:   rtype_alu_ctl = ALU_OR;
      FN_SLT:  rtype_alu_ctl = ALU_SLT;
      default: rtype_alu_ctl = ALU_ADD;
    endcase
  end

  // Saturating wait counter increment; the limit is checked against the
  // incremented value so the WAIT_LIMIT-th stalled cycle is the last one.
  always_comb begin
    wait_inc       = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_ONE;
    wait_limit_hit = ({{(32-TIMEOUT_W){1'b0}}, wait_inc} >= LIMIT);
  end

  // Next-state logic. The wait counter defaults to zero so it clears
  // whenever the FSM is not stalled in FETCH or MEM.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_waitreq) begin
          wait_cnt_d = wait_inc;
          if (wait_limit_hit) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          state_d = S_FETCH;
        end else if (is_jr) begin
          state_d = (reg_a == '0) ? S_HALT : S_FETCH;
        end else if (!is_known) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq || is_bne) begin
          state_d = S_FETCH;
        end else if (is_rtype_alu || is_addiu) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_waitreq) begin
          wait_cnt_d = wait_inc;
          if (wait_limit_hit) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end else begin
          state_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and fault flag. Reset forces IDLE, which in turn
  // forces every strobe low without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  // Strobe decode from the registered phase. In EXEC, operand A is the rs
  // register for every class: address generation and branch compare both
  // need rs, not the PC.
  always_comb begin
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUctl      = ALU_AND;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUctl  = ALU_ADD;
        PCWrite = ~mem_waitreq;
        IRWrite = ~mem_waitreq;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUctl  = ALU_ADD;
        if (is_j) begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end else if (is_jr && (reg_a != '0)) begin
          PCSource = 2'b11;
          PCWrite  = 1'b1;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (is_rtype_alu) begin
          ALUctl = rtype_alu_ctl;
        end else if (is_addiu || is_lw || is_sw) begin
          ALUSrcB = 2'b10;
          ALUctl  = ALU_ADD;
        end else if (is_beq || is_bne) begin
          ALUctl      = ALU_SUB;
          PCSource    = 2'b01;
          PCWriteCond = 1'b1;
          BranchNe    = is_bne;
        end
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype_alu;
        MemtoReg = is_lw;
      end
      default: ;
    endcase
  end

  always_comb begin
    active = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
    fault  = fault_q;
    state  = state_q;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed bench for the multicycle MIPS control unit. Each step drives the
// IR, rs value and memory wait request for one cycle and queues the full
// expected strobe vector for that cycle; checkOutput pops and compares it.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  localparam int DATA_W     = 32;
  localparam int TIMEOUT_W  = 8;
  localparam int WAIT_LIMIT = 200;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  localparam logic [31:0] I_ADDU  = 32'h00221821;
  localparam logic [31:0] I_LW    = 32'h8C220004;
  localparam logic [31:0] I_SW    = 32'hAC220008;
  localparam logic [31:0] I_BNE   = 32'h14220003;
  localparam logic [31:0] I_BEQ   = 32'h10220003;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_ADDIU = 32'h24220005;
  localparam logic [31:0] I_UNK   = 32'hFC000000;
  localparam logic [31:0] I_JR    = 32'h03E00008;

  logic              clk;
  logic              reset_n;
  logic [31:0]       instr;
  logic [DATA_W-1:0] reg_a;
  logic              mem_waitreq;
  logic              RegDst, RegWrite, ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic [3:0]        ALUctl;
  logic [1:0]        PCSource;
  logic              PCWrite, PCWriteCond, BranchNe, IorD;
  logic              MemRead, MemWrite, MemtoReg, IRWrite;
  logic              active, fault;
  logic [2:0]        state;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic       active;
    logic       fault;
    logic [2:0] st;
  } ctl_t;

  ctl_t  observed;
  ctl_t  exp_q[$];
  string tag_q[$];
  int    assert_count = 0;
  int    fail_count   = 0;

  assign observed = {RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUctl, PCSource, PCWrite,
                     PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     active, fault, state};

  mips_multicycle_ctrl #(
    .DATA_W    (DATA_W),
    .TIMEOUT_W (TIMEOUT_W),
    .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr      (instr),
    .reg_a      (reg_a),
    .mem_waitreq(mem_waitreq),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUctl     (ALUctl),
    .PCSource   (PCSource),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .BranchNe   (BranchNe),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .active     (active),
    .fault      (fault),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected strobe vectors per phase.
  function automatic ctl_t idleExp();
    ctl_t c = '0;
    return c;
  endfunction

  function automatic ctl_t busyExp(input logic [2:0] st);
    ctl_t c = '0;
    c.st     = st;
    c.active = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetchExp(input logic done);
    ctl_t c = busyExp(3'd1);
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    c.alu_ctl   = ADD;
    c.pc_write  = done;
    c.ir_write  = done;
    return c;
  endfunction

  function automatic ctl_t decodeExp(input logic [1:0] pcsrc, input logic pcw);
    ctl_t c = busyExp(3'd2);
    c.alu_src_b = 2'b11;
    c.alu_ctl   = ADD;
    c.pc_source = pcsrc;
    c.pc_write  = pcw;
    return c;
  endfunction

  function automatic ctl_t execRExp(input logic [3:0] op);
    ctl_t c = busyExp(3'd3);
    c.alu_src_a = 1'b1;
    c.alu_ctl   = op;
    return c;
  endfunction

  function automatic ctl_t execIExp();
    ctl_t c = busyExp(3'd3);
    c.alu_src_a = 1'b1;
    c.alu_src_b = 2'b10;
    c.alu_ctl   = ADD;
    return c;
  endfunction

  function automatic ctl_t execBrExp(input logic bne);
    ctl_t c = busyExp(3'd3);
    c.alu_src_a     = 1'b1;
    c.alu_ctl       = SUB;
    c.pc_source     = 2'b01;
    c.pc_write_cond = 1'b1;
    c.branch_ne     = bne;
    return c;
  endfunction

  function automatic ctl_t memExp(input logic wr);
    ctl_t c = busyExp(3'd4);
    c.iord      = 1'b1;
    c.mem_read  = ~wr;
    c.mem_write = wr;
    return c;
  endfunction

  function automatic ctl_t wbExp(input logic rd, input logic m2r);
    ctl_t c = busyExp(3'd5);
    c.reg_write = 1'b1;
    c.reg_dst   = rd;
    c.memto_reg = m2r;
    return c;
  endfunction

  function automatic ctl_t haltExp();
    ctl_t c = '0;
    c.st = 3'd6;
    return c;
  endfunction

  function automatic ctl_t faultExp();
    ctl_t c = '0;
    c.st    = 3'd7;
    c.fault = 1'b1;
    return c;
  endfunction

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic checkOutput();
    ctl_t  e;
    string t;
    assert_count++;
    if (exp_q.size() == 0) begin
      fail_count++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=<queued entry>", observed);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (observed === e)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", t, observed, e);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, queue what the DUT
  // must show in that cycle and check it once the inputs have settled.
  task automatic applyStimulus(input logic [31:0] i, input logic [DATA_W-1:0] a,
                               input logic w, input ctl_t e, input string t);
    @(negedge clk);
    instr       = i;
    reg_a       = a;
    mem_waitreq = w;
    exp_q.push_back(e);
    tag_q.push_back(t);
    #1;
    checkOutput();
  endtask

  // Check without waiting for a clock edge (asynchronous reset effects).
  task automatic expectNow(input ctl_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    #1;
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    reset_n     = 1'b1;
    instr       = '0;
    reg_a       = '0;
    mem_waitreq = 1'b0;
    #2 reset_n  = 1'b0;
    expectNow(idleExp(), "reset_async");
    @(negedge clk);
    expectNow(idleExp(), "reset_held");
    reset_n = 1'b1;

    // ADDU, zero wait
    applyStimulus(I_ADDU, 32'h1, 1'b0, fetchExp(1'b1), "addu_fetch");
    applyStimulus(I_ADDU, 32'h1, 1'b0, decodeExp(2'b00, 1'b0), "addu_decode");
    applyStimulus(I_ADDU, 32'h1, 1'b0, execRExp(ADD), "addu_exec");
    applyStimulus(I_ADDU, 32'h1, 1'b0, wbExp(1'b1, 1'b0), "addu_wb");

    // LW, five cycles
    applyStimulus(I_LW, 32'h1, 1'b0, fetchExp(1'b1), "lw_fetch");
    applyStimulus(I_LW, 32'h1, 1'b0, decodeExp(2'b00, 1'b0), "lw_decode");
    applyStimulus(I_LW, 32'h1, 1'b0, execIExp(), "lw_exec");
    applyStimulus(I_LW, 32'h1, 1'b0, memExp(1'b0), "lw_mem");
    applyStimulus(I_LW, 32'h1, 1'b0, wbExp(1'b0, 1'b1), "lw_wb");

    // SW with three fetch wait cycles, then two memory wait cycles
    applyStimulus(I_SW, 32'h1, 1'b1, fetchExp(1'b0), "sw_fetch_wait1");
    applyStimulus(I_SW, 32'h1, 1'b1, fetchExp(1'b0), "sw_fetch_wait2");
    applyStimulus(I_SW, 32'h1, 1'b1, fetchExp(1'b0), "sw_fetch_wait3");
    applyStimulus(I_SW, 32'h1, 1'b0, fetchExp(1'b1), "sw_fetch_go");
    applyStimulus(I_SW, 32'h1, 1'b0, decodeExp(2'b00, 1'b0), "sw_decode");
    applyStimulus(I_SW, 32'h1, 1'b0, execIExp(), "sw_exec");
    applyStimulus(I_SW, 32'h1, 1'b1, memExp(1'b1), "sw_mem_wait1");
    applyStimulus(I_SW, 32'h1, 1'b1, memExp(1'b1), "sw_mem_wait2");
    applyStimulus(I_SW, 32'h1, 1'b0, memExp(1'b1), "sw_mem_done");

    // BNE, then J
    applyStimulus(I_BNE, 32'h1, 1'b0, fetchExp(1'b1), "bne_fetch");
    applyStimulus(I_BNE, 32'h1, 1'b0, decodeExp(2'b00, 1'b0), "bne_decode");
    applyStimulus(I_BNE, 32'h1, 1'b0, execBrExp(1'b1), "bne_exec");
    applyStimulus(I_J, 32'h1, 1'b0, fetchExp(1'b1), "bne_next_fetch");
    applyStimulus(I_J, 32'h1, 1'b0, decodeExp(2'b10, 1'b1), "j_decode");

    // ADDIU writes rt
    applyStimulus(I_ADDIU, 32'h1, 1'b0, fetchExp(1'b1), "addiu_fetch");
    applyStimulus(I_ADDIU, 32'h1, 1'b0, decodeExp(2'b00, 1'b0), "addiu_decode");
    applyStimulus(I_ADDIU, 32'h1, 1'b0, execIExp(), "addiu_exec");
    applyStimulus(I_ADDIU, 32'h1, 1'b0, wbExp(1'b0, 1'b0), "addiu_wb");

    // BEQ, then an unknown opcode behaves as a NOP
    applyStimulus(I_BEQ, 32'h1, 1'b0, fetchExp(1'b1), "beq_fetch");
    applyStimulus(I_BEQ, 32'h1, 1'b0, decodeExp(2'b00, 1'b0), "beq_decode");
    applyStimulus(I_BEQ, 32'h1, 1'b0, execBrExp(1'b0), "beq_exec");
    applyStimulus(I_UNK, 32'h1, 1'b0, fetchExp(1'b1), "nop_fetch");
    applyStimulus(I_UNK, 32'h1, 1'b0, decodeExp(2'b00, 1'b0), "nop_decode");

    // JR to a nonzero target, then reset in the middle of a stalled fetch
    applyStimulus(I_JR, 32'h40, 1'b0, fetchExp(1'b1), "jr40_fetch");
    applyStimulus(I_JR, 32'h40, 1'b0, decodeExp(2'b11, 1'b1), "jr40_decode");
    applyStimulus(I_JR, 32'h40, 1'b1, fetchExp(1'b0), "jr40_next_fetch_wait");
    #2 reset_n = 1'b0;
    expectNow(idleExp(), "reset_mid_fetch");
    @(negedge clk);
    reset_n = 1'b1;

    // JR to zero halts without a PC write
    applyStimulus(I_JR, 32'h0, 1'b0, fetchExp(1'b1), "jr0_fetch");
    applyStimulus(I_JR, 32'h0, 1'b0, decodeExp(2'b00, 1'b0), "jr0_decode");
    applyStimulus(I_JR, 32'h0, 1'b0, haltExp(), "jr0_halt");
    applyStimulus(I_ADDU, 32'h1, 1'b0, haltExp(), "halt_sticky");
    reset_n = 1'b0;
    expectNow(idleExp(), "reset_from_halt");
    @(negedge clk);
    reset_n = 1'b1;

    // SW stalled in MEM until the wait limit trips
    applyStimulus(I_SW, 32'h1, 1'b0, fetchExp(1'b1), "tmo_fetch");
    applyStimulus(I_SW, 32'h1, 1'b0, decodeExp(2'b00, 1'b0), "tmo_decode");
    applyStimulus(I_SW, 32'h1, 1'b0, execIExp(), "tmo_exec");
    for (int k = 1; k <= WAIT_LIMIT; k++) begin
      applyStimulus(I_SW, 32'h1, 1'b1, memExp(1'b1), $sformatf("tmo_mem_wait%0d", k));
    end
    applyStimulus(I_SW, 32'h1, 1'b1, faultExp(), "tmo_fault");
    applyStimulus(I_SW, 32'h1, 1'b0, faultExp(), "fault_sticky");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
